// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential restoring divider:
//   state_t    - controller state encoding (IDLE / CALC / DONE)
//   cnt_width  - width of the iteration counter for an n-bit divider
// -----------------------------------------------------------------------------
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must be able to hold the value n itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Request/result bundle of the sequential divider.
//   start        requester -> divider  begin a divide (sampled in IDLE)
//   dividend     requester -> divider  unsigned dividend, n bits
//   divisor      requester -> divider  unsigned divisor, n bits
//   busy         divider -> requester  operation in progress
//   done         divider -> requester  one-cycle result-valid pulse
//   quotient     divider -> requester  unsigned quotient, n bits
//   remainder    divider -> requester  unsigned remainder, n bits
//   div_by_zero  divider -> requester  divisor was zero
// master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface seq_divider_if #(parameter int n = 8);
   import seq_divider_pkg::*;

   logic         start;
   logic [n-1:0] dividend;
   logic [n-1:0] divisor;
   logic         busy;
   logic         done;
   logic [n-1:0] quotient;
   logic [n-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_divider_add_sub.sv
// -----------------------------------------------------------------------------
// rca_add_sub
// n-bit ripple-carry adder/subtractor.
//   a, b      operands
//   con       1 = subtract (b is inverted), 0 = add
//   cin       carry in (XORed with con, so con=1/cin=0 yields a + ~b + 1)
//   sum       n-bit result
//   cout      carry out of the top bit (1 on subtract means a >= b)
//   b_comp    conditioned b actually fed to the adder
//   cin_comp  conditioned carry actually fed to bit 0
// -----------------------------------------------------------------------------
module rca_add_sub #(
   parameter int n = 8
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         con,
   input  logic         cin,
   output logic [n-1:0] sum,
   output logic         cout,
   output logic [n-1:0] b_comp,
   output logic         cin_comp
);
   import seq_divider_pkg::*;

   logic [n:0] carry;

   // Operand conditioning followed by the ripple-carry chain.
   always_comb begin
      if (con) begin
         b_comp = ~b;
      end else begin
         b_comp = b;
      end
      cin_comp = cin ^ con;
      carry    = {(n + 1){1'b0}};
      sum      = {n{1'b0}};
      carry[0] = cin_comp;
      for (int i = 0; i < n; i++) begin
         sum[i]       = a[i] ^ b_comp[i] ^ carry[i];
         carry[i + 1] = (a[i] & b_comp[i]) | (carry[i] & (a[i] ^ b_comp[i]));
      end
      cout = carry[n];
   end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative unsigned restoring divider, one quotient bit per clock. Trial
// subtractions are performed by an rca_add_sub instance.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  seq_divider_if.slave (start/operands in, busy/done/results out)
// Divide by zero finishes in one edge with quotient all ones, remainder =
// dividend and div_by_zero set.
// -----------------------------------------------------------------------------
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);

   localparam int cw = cnt_width(n);
   localparam logic [cw-1:0] cnt_one  = {{(cw - 1){1'b0}}, 1'b1};
   localparam logic [cw-1:0] cnt_load = cw'(n);

   state_t        state;
   state_t        next_state;
   logic [n-1:0]  r;
   logic [n-1:0]  q;
   logic [n-1:0]  d;
   logic [cw-1:0] count;
   logic          busy_flag;
   logic          done_flag;
   logic          dbz_flag;

   logic          msb_out;
   logic [n-1:0]  rs;
   logic [n-1:0]  qs;
   logic [n-1:0]  diff;
   logic          cout;
   logic          take;

   // Trial subtraction rs - d.
   rca_add_sub #(.n(n)) u_add_sub (
      .a        (rs),
      .b        (d),
      .con      (1'b1),
      .cin      (1'b0),
      .sum      (diff),
      .cout     (cout),
      .b_comp   (),
      .cin_comp ()
   );

   // Shift {R,Q} left and decide whether the trial subtraction is kept.
   // A bit shifted out of R means the partial remainder exceeds d, so the
   // n-bit difference is exact even though cout is 0.
   always_comb begin
      msb_out = r[n-1];
      rs      = {r[n-2:0], q[n-1]};
      qs      = {q[n-2:0], 1'b0};
      take    = msb_out | cout;
   end

   // Controller next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor != {n{1'b0}}) begin
                  next_state = CALC;
               end else begin
                  next_state = DONE;
               end
            end else begin
               next_state = IDLE;
            end
         end
         CALC: begin
            if (count == cnt_one) begin
               next_state = DONE;
            end else begin
               next_state = CALC;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State, status flags and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy_flag <= 1'b0;
         done_flag <= 1'b0;
         dbz_flag  <= 1'b0;
         r         <= {n{1'b0}};
         q         <= {n{1'b0}};
         d         <= {n{1'b0}};
         count     <= {cw{1'b0}};
      end else begin
         state     <= next_state;
         busy_flag <= (next_state != IDLE);
         done_flag <= (next_state == DONE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.divisor != {n{1'b0}}) begin
                     r        <= {n{1'b0}};
                     q        <= bus.dividend;
                     d        <= bus.divisor;
                     count    <= cnt_load;
                     dbz_flag <= 1'b0;
                  end else begin
                     r        <= bus.dividend;
                     q        <= {n{1'b1}};
                     dbz_flag <= 1'b1;
                  end
               end
            end
            CALC: begin
               count <= count - cnt_one;
               if (take) begin
                  r <= diff;
                  q <= qs | {{(n - 1){1'b0}}, 1'b1};
               end else begin
                  r <= rs;
                  q <= qs;
               end
            end
            default: begin
               count <= count;
            end
         endcase
      end
   end

   assign bus.busy        = busy_flag;
   assign bus.done        = done_flag;
   assign bus.div_by_zero = dbz_flag;
   assign bus.quotient    = q;
   assign bus.remainder   = r;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider. It issues trial subtractions to the team's n-bit ripple-carry add/sub stage and consumes the sum and cout it returns, one quotient bit per clock.
- It sits directly upstream of the add/sub stage as its operand sequencer and result consumer.
- It gives the ALU divide support without a combinational array divider.

Parameters:
- n, 8, operand width (dividend, divisor, quotient, remainder); minimum 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a divide; sampled only in IDLE
- dividend  input  n  unsigned dividend; sampled on the accepting edge
- divisor  input  n  unsigned divisor; sampled on the accepting edge
- busy  output  1  high while an operation is in progress (CALC or DONE)
- done  output  1  one-cycle pulse; results valid
- quotient  output  n  unsigned quotient
- remainder  output  n  unsigned remainder
- div_by_zero  output  1  set with done when divisor was 0; held with the results

Behaviour:
- Reset: rst high at a rising edge forces these values, overriding any operation in progress:
  - state = IDLE, busy = 0, done = 0, div_by_zero = 0
  - quotient = 0, remainder = 0, iteration counter = 0
  - The aborted operation produces no done.
- States and transitions:
  - IDLE -> CALC: start=1 and divisor != 0. Load R = 0, Q = dividend, D = divisor, count = n, clear div_by_zero.
  - IDLE -> DONE: start=1 and divisor = 0. Set Q = all ones, R = dividend, div_by_zero = 1.
  - CALC -> CALC: one iteration per edge; count decrements.
  - CALC -> DONE: on the edge where count reaches 0.
  - DONE -> IDLE: unconditionally after one cycle.
- Iteration, using the registered values:
  - Shift {R,Q} left by 1: msb_out = R[n-1]; Rs = {R[n-2:0], Q[n-1]}; Qs = {Q[n-2:0], 0}.
  - Drive the add/sub stage with a = Rs, b = D, con = 1, cin = 0. This computes Rs + ~D + 1, giving diff (n bits) and cout.
  - If msb_out = 1 or cout = 1: R <= diff, Q <= Qs | 1.
  - Otherwise restore: R <= Rs, Q <= Qs.
  - The n-bit diff is exact modulo 2^n when msb_out = 1.
- Outputs:
  - quotient and remainder are driven from the Q and R registers.
  - They are valid, and guaranteed stable, from the done cycle until the next accepting edge; intermediate values are visible during CALC.
- done:
  - Asserted for exactly the one cycle spent in DONE.
  - Latency from the accepting edge to done high is n+1 edges for a normal divide (9 for n=8), and 1 edge for divide by zero.
- busy: high in CALC and DONE, low only in IDLE.
- start while busy is ignored, including in the DONE cycle; it is not queued.
- Input changes after the accepting edge do not affect the operation in progress.
- Edge cases:
  - Back-to-back: start held high is accepted on the first edge after returning to IDLE, so the minimum spacing between accepting edges is n+2 cycles.
  - Simultaneous rst and start: rst wins.
  - dividend = 0: quotient 0, remainder 0, normal latency.
  - divisor = 1: quotient = dividend, remainder 0.
  - dividend < divisor: quotient 0, remainder = dividend.

Decomposition:
- Shared header (`define include, same style as other datapath includes):
  - state encodings IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2
  - counter width = clog2(n+1)
- One sub-module: instance of the existing n-bit rca_add_sub, parameter n passed through, wired as above. Its b_comp/cin_comp outputs are left unconnected.
- Controller, counter and R/Q/D registers live in seq_divider itself.

Test Plan:
- Basic divide, n=8: dividend=100, divisor=7, start one cycle -> busy high next cycle; done pulses exactly 9 edges after the accepting edge; quotient=14, remainder=2, div_by_zero=0; busy low the cycle after done.
- MSB/carry path: 255/1 -> q=255, r=0; 200/128 -> q=1, r=72; 255/255 -> q=1, r=0; 5/9 -> q=0, r=5.
- Divide by zero: dividend=200, divisor=0 -> done 1 edge after accept; div_by_zero=1, quotient=255, remainder=200. Next normal divide 10/3 -> div_by_zero=0, q=3, r=1.
- Handshake:
  - Start pulsed at cycle 3 of a 100/7 operation with 50/5 on the inputs -> ignored; result still 14 r 2.
  - Start held high continuously with operands 50/5 -> second accept on the edge after done, next done 10 edges after the first; q=10, r=0.
- Reset mid-operation: rst asserted at cycle 4 of 100/7 -> next edge busy=0, done=0, q=0, r=0; no done pulse. Fresh 9/2 then gives q=4, r=1.
- Randomised sweep: 1000 random pairs with divisor != 0 -> quotient*divisor + remainder == dividend and remainder < divisor; latency always n+1.
